j_jmem_ctl: RTL and testbench

- Parametrised successor to the DSP external-memory cycle controller.
- Accepts one CPU-side transfer at a time, up to CPU_W bits wide.
- Arbitrates for the system bus with request/grant, then runs one or more bus beats on a port of BUS_W bits (or BUS_W/2 in narrow mode), each terminated by an external dtack.
- Packs read beats into a CPU-width word, then acks the CPU. Sits between the DSP local bus and the system bus pads.

---
 rtl/j_jmem_pkg.sv | 25 ++
 rtl/j_jmem_pack.sv | 38 +++
 rtl/j_jmem_ctl.sv | 175 +++++++++++++++++
 tb/tb_j_jmem_ctl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/j_jmem_pkg.sv
// Shared types and helpers for the j_jmem external-memory cycle controller.
package j_jmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        DATA,
        NEXT,
        DONE
    } state_e;

    localparam logic [2:0] SZ_8  = 3'd0;
    localparam logic [2:0] SZ_16 = 3'd1;
    localparam logic [2:0] SZ_32 = 3'd2;
    localparam logic [2:0] SZ_64 = 3'd3;

    // Beats needed to move 2^size bytes over a port of 2^lpb bytes.
    function automatic logic [3:0] beat_count(input logic [2:0] size,
                                              input logic [2:0] lpb);
        if (size > lpb) return 4'd1 << (size - lpb);
        return 4'd1;
    endfunction

endpackage

// File: rtl/j_jmem_pack.sv
// Beat slice selection for writes and read-word assembly for reads.
import j_jmem_pkg::*;

module j_jmem_pack #(
    parameter int CPU_W = 64,
    parameter int BUS_W = 32
) (
    input  logic [3:0]       beat_i,
    input  logic [3:0]       nbeats_i,
    input  logic             bigend_i,
    input  logic [3:0]       lane_i,
    input  logic [1:0]       bsize_i,
    input  logic [CPU_W-1:0] wdata_i,
    input  logic [CPU_W-1:0] acc_i,
    input  logic [BUS_W-1:0] rdata_i,
    output logic [BUS_W-1:0] wslice_o,
    output logic [CPU_W-1:0] acc_o
);

    logic [3:0]       slice;
    logic [9:0]       pos;
    logic [6:0]       lsh;
    logic [CPU_W-1:0] bmask;
    logic [CPU_W-1:0] port;

    always_comb begin
        slice = bigend_i ? (nbeats_i - 4'd1 - beat_i) : beat_i;
        pos   = 10'(slice) << (4'd3 + 4'(bsize_i));
        lsh   = {lane_i, 3'd0};
        bmask = ~({CPU_W{1'b1}} << (7'd8 << bsize_i));
        port  = CPU_W'(rdata_i);
        // Narrow ports live in the low half, so lane + beat size never
        // reaches past the active bytes.
        acc_o    = acc_i | (((port >> lsh) & bmask) << pos);
        wslice_o = BUS_W'(((wdata_i >> pos) & bmask) << lsh);
    end

endmodule

// File: rtl/j_jmem_ctl.sv
// External-memory cycle controller: arbitration, multi-beat bus cycles, read packing.
// Optional dtack watchdog enabled by defining JMEM_TIMEOUT_EN.
import j_jmem_pkg::*;

module j_jmem_ctl #(
    parameter int CPU_W       = 64,
    parameter int BUS_W       = 32,
    parameter int ADDR_W      = 24,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              narrow,
    input  logic              bigend,
    input  logic              req_valid,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [CPU_W-1:0]  req_wdata,
    output logic              req_ack,
    output logic [CPU_W-1:0]  req_rdata,
    output logic              req_err,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [2:0]        bus_siz,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic              bus_den,
    output logic [BUS_W-1:0]  bus_wdata,
    input  logic [BUS_W-1:0]  bus_rdata,
    input  logic              bus_dtack
);

    localparam logic [2:0] LBB   = 3'($clog2(BUS_W / 8));
    localparam logic [2:0] MAXSZ = 3'($clog2(CPU_W / 8));

    state_e            state_q, state_d;
    logic              rw_q, narrow_q, bigend_q;
    logic [2:0]        size_q, size_c;
    logic [ADDR_W-1:0] addr_q;
    logic [CPU_W-1:0]  wdata_q, acc_q, acc_nxt;
    logic [3:0]        beat_q;
    logic [2:0]        lpb;
    logic [3:0]        pb, nbeats, off, lane;
    logic [1:0]        bsize;
    logic [BUS_W-1:0]  wslice;
    logic              tmo;

    assign size_c = (req_size > MAXSZ) ? MAXSZ : req_size;

    always_comb begin
        lpb    = narrow_q ? (LBB - 3'd1) : LBB;
        pb     = 4'd1 << lpb;
        bsize  = 2'((size_q > lpb) ? lpb : size_q);
        nbeats = beat_count(size_q, lpb);
        off    = {1'b0, addr_q[2:0]} & (pb - 4'd1);
        // Big-endian byte lanes count down from the top of the port.
        if (size_q >= lpb)
            lane = 4'd0;
        else if (bigend_q)
            lane = pb - off - (4'd1 << size_q);
        else
            lane = off;
    end

    j_jmem_pack #(
        .CPU_W (CPU_W),
        .BUS_W (BUS_W)
    ) u_pack (
        .beat_i   (beat_q),
        .nbeats_i (nbeats),
        .bigend_i (bigend_q),
        .lane_i   (lane),
        .bsize_i  (bsize),
        .wdata_i  (wdata_q),
        .acc_i    (acc_q),
        .rdata_i  (bus_rdata),
        .wslice_o (wslice),
        .acc_o    (acc_nxt)
    );

`ifdef JMEM_TIMEOUT_EN
    logic [15:0] tcnt_q;
    logic        err_q;

    assign tmo     = (state_q == DATA) && !bus_dtack
                     && (tcnt_q == 16'(TIMEOUT_CYC - 1));
    assign req_err = req_ack && err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == ADDR)
                tcnt_q <= '0;
            else if (state_q == DATA && !bus_dtack)
                tcnt_q <= tcnt_q + 16'd1;
            if (state_q == IDLE)
                err_q <= 1'b0;
            else if (tmo)
                err_q <= 1'b1;
        end
    end
`else
    assign tmo     = 1'b0;
    assign req_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid) state_d = ARB;
            ARB:  if (bus_grant) state_d = ADDR;
            ADDR: state_d = DATA;
            DATA: begin
                if (bus_dtack)
                    state_d = (beat_q == nbeats - 4'd1) ? DONE : NEXT;
                else if (tmo)
                    state_d = DONE;
            end
            NEXT: state_d = ADDR;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rw_q     <= 1'b0;
            narrow_q <= 1'b0;
            bigend_q <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            acc_q    <= '0;
            beat_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                rw_q     <= req_rw;
                narrow_q <= narrow;
                bigend_q <= bigend;
                size_q   <= size_c;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                acc_q    <= '0;
                beat_q   <= '0;
            end
            if (state_q == DATA && bus_dtack && rw_q)
                acc_q <= acc_nxt;
            if (tmo)
                acc_q <= '0;
            if (state_q == NEXT) begin
                beat_q <= beat_q + 4'd1;
                addr_q <= addr_q + ADDR_W'(pb);
            end
        end
    end

    assign bus_req   = (state_q == ARB) || (state_q == ADDR)
                       || (state_q == DATA) || (state_q == NEXT);
    assign bus_rd    = (state_q == DATA) && rw_q;
    assign bus_wr    = (state_q == DATA) && !rw_q;
    assign bus_den   = !rw_q && ((state_q == ADDR) || (state_q == DATA));
    assign bus_siz   = ((state_q == ADDR) || (state_q == DATA))
                       ? {1'b0, bsize} : 3'd0;
    assign bus_addr  = addr_q;
    assign bus_wdata = bus_den ? wslice : '0;
    assign req_ack   = (state_q == DONE);
    assign req_rdata = req_ack ? acc_q : '0;

endmodule

// File: tb/tb_j_jmem_ctl.sv
// Directed scoreboard bench for j_jmem_ctl (CPU_W=64, BUS_W=32, TIMEOUT_CYC=8).
`timescale 1ns/1ps
module tb_j_jmem_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        narrow = 1'b0, bigend = 1'b0;
    logic        req_valid = 1'b0, req_rw = 1'b0;
    logic [23:0] req_addr = '0;
    logic [2:0]  req_size = '0;
    logic [63:0] req_wdata = '0;
    logic        req_ack, req_err, bus_req;
    logic [63:0] req_rdata;
    logic        bus_grant = 1'b0;
    logic [23:0] bus_addr;
    logic [2:0]  bus_siz;
    logic        bus_rd, bus_wr, bus_den;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_dtack = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [23:0] addr;
        logic [2:0]  siz;
        logic [31:0] wdata;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] rdq[$];
    logic [63:0] exp_rd_q[$];

    j_jmem_ctl #(
        .CPU_W(64), .BUS_W(32), .ADDR_W(24), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .reset(reset), .narrow(narrow), .bigend(bigend),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata), .req_ack(req_ack),
        .req_rdata(req_rdata), .req_err(req_err), .bus_req(bus_req),
        .bus_grant(bus_grant), .bus_addr(bus_addr), .bus_siz(bus_siz),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_den(bus_den),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_dtack(bus_dtack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [23:0] a, input logic [2:0] s,
                             input logic [31:0] wd);
        beat_t b;
        b.addr = a; b.siz = s; b.wdata = wd;
        exp_q.push_back(b);
    endtask

    // Runs one transfer, acting as arbiter and memory; beats are checked
    // against exp_q, completion against exp_rd_q / latency / error flag.
    task automatic xfer(input logic rw, input logic [23:0] a,
                        input logic [2:0] sz, input logic [63:0] wd,
                        input logic nar, input logic big,
                        input int gdly, input int ddly, input logic spur,
                        input int exp_lat, input logic exp_err);
        int    cyc, w;
        bit    granted, done;
        beat_t eb;
        @(negedge clk);
        req_rw = rw; req_addr = a; req_size = sz; req_wdata = wd;
        narrow = nar; bigend = big; req_valid = 1'b1;
        bus_grant = (gdly == 0); bus_dtack = spur;
        cyc = 0; w = 0; granted = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus_grant) granted = 1;
            bus_grant = (cyc >= gdly);
            if (cyc == 5 && gdly > 5) check("bus_req_hold", bus_req, 1);
            if (bus_rd || bus_wr) begin
                if (w == 0) begin
                    check("strobe_after_grant", granted, 1);
                    check("strobe_dir", bus_rd, rw);
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        eb = exp_q.pop_front();
                        check("beat_addr", bus_addr, eb.addr);
                        check("beat_siz", bus_siz, eb.siz);
                        check("beat_den", bus_den, !rw);
                        if (!rw) check("beat_wdata", bus_wdata, eb.wdata);
                    end
                end
                if (w == ddly) begin
                    bus_dtack = 1'b1;
                    if (rw && rdq.size() > 0) bus_rdata = rdq.pop_front();
                    w = 0;
                end else begin
                    bus_dtack = 1'b0;
                    w++;
                end
            end else begin
                bus_dtack = spur;
            end
            if (req_ack) begin
                done = 1;
                check("ack_latency", cyc, exp_lat);
                check("ack_err", req_err, exp_err);
                check("strobes_at_ack", {bus_rd, bus_wr, bus_den, bus_req}, 0);
                if (rw && exp_rd_q.size() > 0)
                    check("ack_rdata", req_rdata, exp_rd_q.pop_front());
            end
        end
        if (!done) check("ack_timeout", 0, 1);
        // req_valid still high here: the ack cycle must not re-accept it.
        @(negedge clk);
        check("no_reaccept", bus_req, 0);
        check("ack_single", req_ack, 0);
        check("sb_empty", exp_q.size(), 0);
        req_valid = 1'b0; bus_grant = 1'b0; bus_dtack = 1'b0; bus_rdata = '0;
        exp_q.delete(); rdq.delete(); exp_rd_q.delete();
    endtask

    initial begin
        int acks;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {req_ack, req_err, bus_req, bus_rd, bus_wr, bus_den}, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_siz", bus_siz, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_rdata", req_rdata, 0);
        reset = 1'b0;

        // 64-bit big-endian read, two beats
        push_beat(24'h100, 3'd2, '0); push_beat(24'h104, 3'd2, '0);
        rdq.push_back(32'h11223344); rdq.push_back(32'h55667788);
        exp_rd_q.push_back(64'h1122334455667788);
        xfer(1, 24'h100, 3'd3, '0, 0, 1, 0, 0, 0, 7, 0);

        // same, little-endian
        push_beat(24'h100, 3'd2, '0); push_beat(24'h104, 3'd2, '0);
        rdq.push_back(32'h11223344); rdq.push_back(32'h55667788);
        exp_rd_q.push_back(64'h5566778811223344);
        xfer(1, 24'h100, 3'd3, '0, 0, 0, 0, 0, 0, 7, 0);

        // narrow 32-bit write, big-endian
        push_beat(24'h200, 3'd1, 32'h0000CAFE);
        push_beat(24'h202, 3'd1, 32'h0000BABE);
        xfer(0, 24'h200, 3'd2, 64'hCAFEBABE, 1, 1, 0, 0, 0, 7, 0);

        // wide 64-bit write, little-endian
        push_beat(24'h300, 3'd2, 32'h89ABCDEF);
        push_beat(24'h304, 3'd2, 32'h01234567);
        xfer(0, 24'h300, 3'd3, 64'h0123456789ABCDEF, 0, 0, 0, 0, 0, 7, 0);

        // byte read, big-endian lane select
        push_beat(24'h3, 3'd0, '0);
        rdq.push_back(32'hAABBCCDD);
        exp_rd_q.push_back(64'hDD);
        xfer(1, 24'h3, 3'd0, '0, 0, 1, 0, 0, 0, 4, 0);

        // narrow byte read, little-endian lane select
        push_beat(24'h501, 3'd0, '0);
        rdq.push_back(32'h00001234);
        exp_rd_q.push_back(64'h12);
        xfer(1, 24'h501, 3'd0, '0, 1, 0, 0, 0, 0, 4, 0);

        // oversize request clamps to 64 bits
        push_beat(24'h400, 3'd2, '0); push_beat(24'h404, 3'd2, '0);
        rdq.push_back(32'hDEADBEEF); rdq.push_back(32'h01020304);
        exp_rd_q.push_back(64'hDEADBEEF01020304);
        xfer(1, 24'h400, 3'd7, '0, 0, 1, 0, 0, 0, 7, 0);

        // late grant, slow dtack, spurious dtack outside DATA
        push_beat(24'h40, 3'd2, '0);
        rdq.push_back(32'h89ABCDEF);
        exp_rd_q.push_back(64'h89ABCDEF);
        xfer(1, 24'h40, 3'd2, '0, 0, 0, 10, 5, 1, 18, 0);

`ifdef JMEM_TIMEOUT_EN
        push_beat(24'h700, 3'd2, '0);
        exp_rd_q.push_back(64'h0);
        xfer(1, 24'h700, 3'd2, '0, 0, 0, 0, 1000, 0, 11, 1);
`endif

        // reset in the middle of DATA abandons the transfer
        @(negedge clk);
        req_rw = 1'b1; req_addr = 24'h600; req_size = 3'd2;
        narrow = 1'b0; bigend = 1'b0; req_valid = 1'b1; bus_grant = 1'b1;
        for (int i = 0; i < 20 && !bus_rd; i++) @(negedge clk);
        check("reach_data", bus_rd, 1);
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("midrst_ctrl", {req_ack, req_err, bus_req, bus_rd, bus_wr, bus_den}, 0);
        check("midrst_addr", bus_addr, 0);
        check("midrst_siz", bus_siz, 0);
        check("midrst_wdata", bus_wdata, 0);
        check("midrst_rdata", req_rdata, 0);
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ack) acks++;
        end
        check("midrst_no_ack", acks, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
